// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared types for the load/store data memory.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Load and store encodings share values, so one set of names covers both.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/load_store_memory_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : load_align
//  Brief    : Selects the addressed lane(s) of a word and sign/zero-extends.
//  Revision : 1.0 - initial release
// ============================================================================
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word_i[7:0];
        case (addr_lo_i)
            2'd0:    w_byte = word_i[7:0];
            2'd1:    w_byte = word_i[15:8];
            2'd2:    w_byte = word_i[23:16];
            default: w_byte = word_i[31:24];
        endcase
        w_half = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = '0;
        case (funct3_i)
            MEM_B:   data_o = {{24{w_byte[7]}}, w_byte};
            MEM_H:   data_o = {{16{w_half[15]}}, w_half};
            MEM_W:   data_o = word_i;
            MEM_BU:  data_o = {24'd0, w_byte};
            MEM_HU:  data_o = {16'd0, w_half};
            default: data_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_memory.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_memory
//  Brief    : RV32I byte/half/word data memory with request/response handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_memory
    import lsu_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_address,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    input  logic [32*DEPTH-1:0]   initial_values,
    output logic [32*DEPTH-1:0]   memory_check
);

    localparam int C_CNT_W = $clog2(LATENCY + 1);
    localparam int C_IDX_W = $clog2(DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(LATENCY - 1);

    lsu_state_t         state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        rdata_q;
    logic               error_q;

    logic        w_accept;
    logic [29:0] w_idx;
    logic        w_in_range;
    logic        w_funct3_ok;
    logic        w_misalign;
    logic        w_error;
    logic [31:0] w_word;
    logic [31:0] w_load_data;
    logic [3:0]  w_be;
    logic [31:0] w_lanes;
    logic [31:0] w_merged;

    assign w_accept   = req_valid && req_ready;
    assign w_idx      = req_address[31:2];
    assign w_in_range = ({2'b00, w_idx} < 32'(DEPTH));
    assign w_word     = w_in_range ? mem_q[w_idx[C_IDX_W-1:0]] : '0;

    always_comb begin
        w_funct3_ok = req_write ? (req_funct3 inside {MEM_B, MEM_H, MEM_W})
                                : (req_funct3 inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU});
        w_misalign  = ((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
        w_error     = !w_in_range || w_misalign || !w_funct3_ok;
    end

    // Replicate the store data across lanes so the byte enables alone pick placement.
    always_comb begin
        w_be    = 4'b0000;
        w_lanes = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << req_address[1:0];
                w_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req_address[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{req_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        for (int b = 0; b < 4; b++) begin
            w_merged[8*b +: 8] = w_be[b] ? w_lanes[8*b +: 8] : w_word[8*b +: 8];
        end
    end

    load_align u_load_align (
        .word_i    (w_word),
        .addr_lo_i (req_address[1:0]),
        .funct3_i  (req_funct3),
        .data_o    (w_load_data)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = C_CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - C_CNT_ONE;
                if (cnt_q == C_CNT_ONE) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
    end

    // Memory and response registers; the store commits at accept, not at response.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= initial_values[i*32 +: 32];
            end
            rdata_q <= '0;
            error_q <= 1'b0;
        end else if (w_accept) begin
            if (req_write && !w_error) begin
                mem_q[w_idx[C_IDX_W-1:0]] <= w_merged;
            end
            rdata_q <= (req_write || w_error) ? 32'd0 : w_load_data;
            error_q <= w_error;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_mem_check
        assign memory_check[g*32 +: 32] = mem_q[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_memory
//  Brief    : Self-checking bench for load_store_memory (DEPTH=16, LATENCY=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_memory;

    localparam int DEPTH   = 16;
    localparam int LATENCY = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [2:0]           req_funct3;
    logic [31:0]          req_address;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_rdata;
    logic                 resp_error;
    logic [32*DEPTH-1:0]  initial_values;
    logic [32*DEPTH-1:0]  memory_check;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_memory #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_address    (req_address),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .initial_values (initial_values),
        .memory_check   (memory_check)
    );

    always #5 clk = ~clk;

    // Reference model: byte-level memory and a transaction-age view of the handshake.
    logic [31:0] m_mem [DEPTH];
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    logic [31:0] m_rd   = '0;
    bit          m_er   = 1'b0;
    bit          m_live = 1'b0;

    function automatic void model_access(input bit wr, input bit [2:0] f3,
                                         input bit [31:0] a, input bit [31:0] wd);
        int    size;
        int    off;
        int    idx;
        bit    legal;
        longint val;
        longint mask;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        idx   = int'(a >> 2);
        off   = int'(a % 4);
        m_er  = !legal || ((a % size) != 0) || (idx >= DEPTH);
        m_rd  = 32'd0;
        if (!m_er) begin
            if (wr) begin
                for (int b = 0; b < size; b++) begin
                    m_mem[idx][8*(off+b) +: 8] = wd[8*b +: 8];
                end
            end else begin
                mask = (longint'(1) << (8*size)) - 1;
                val  = (longint'(m_mem[idx]) >> (8*off)) & mask;
                if (!f3[2] && size < 4 && val >= (mask + 1) / 2) begin
                    val = val - (mask + 1);
                end
                m_rd = val[31:0];
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = initial_values[i*32 +: 32];
            m_busy = 1'b0;
            m_live = 1'b1;
        end else if (m_busy) begin
            if (m_age >= LATENCY - 1 && resp_ready) m_busy = 1'b0;
            else m_age++;
        end else if (req_valid) begin
            model_access(req_write, req_funct3, req_address, req_wdata);
            m_busy = 1'b1;
            m_age  = 0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        bit exp_valid;
        bit mem_ok;
        if (m_live) begin
            exp_valid = m_busy && (m_age >= LATENCY - 1);
            mem_ok    = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (memory_check[i*32 +: 32] !== m_mem[i]) mem_ok = 1'b0;
            end
            n_tests++;
            if (req_ready !== !m_busy || resp_valid !== exp_valid || !mem_ok ||
                (exp_valid && (resp_rdata !== m_rd || resp_error !== m_er))) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t ready=%b exp=%b valid=%b exp=%b rdata=%h exp=%h err=%b exp=%b mem_ok=%b",
                         $time, req_ready, !m_busy, resp_valid, exp_valid,
                         resp_rdata, m_rd, resp_error, m_er, mem_ok);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mw(input int i);
        return memory_check[i*32 +: 32];
    endfunction

    function automatic logic [31:0] iw(input int i);
        return initial_values[i*32 +: 32];
    endfunction

    // Issue one request from idle, check latency and literal response, then consume it.
    task automatic do_req(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input bit [31:0] exp_rd,
                          input bit exp_er, input string nm);
        int k;
        req_valid   = 1'b1;
        req_write   = wr;
        req_funct3  = f3;
        req_address = a;
        req_wdata   = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 1;
        while (resp_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_latency"}, k, LATENCY);
        chk({nm, "_rdata"}, resp_rdata, exp_rd);
        chk({nm, "_error"}, {31'd0, resp_error}, {31'd0, exp_er});
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) initial_values[i*32 +: 32] = 32'h1111_0000 + i;
        initial_values[1*32 +: 32] = 32'h8081_7F01;
        initial_values[2*32 +: 32] = 32'h0000_0000;

        // Reset with a store presented; it must not be accepted.
        reset       = 1'b1;
        resp_ready  = 1'b1;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_funct3  = 3'b010;
        req_address = 32'd0;
        req_wdata   = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_mem0", mw(0), 32'h1111_0000);

        do_req(1'b0, 3'b010, 32'd4, 32'd0, 32'h8081_7F01, 1'b0, "lw4");
        do_req(1'b0, 3'b000, 32'd7, 32'd0, 32'hFFFF_FF80, 1'b0, "lb7");
        do_req(1'b0, 3'b100, 32'd7, 32'd0, 32'h0000_0080, 1'b0, "lbu7");
        do_req(1'b0, 3'b001, 32'd6, 32'd0, 32'hFFFF_8081, 1'b0, "lh6");
        do_req(1'b0, 3'b101, 32'd6, 32'd0, 32'h0000_8081, 1'b0, "lhu6");
        do_req(1'b0, 3'b000, 32'd5, 32'd0, 32'h0000_007F, 1'b0, "lb5");

        do_req(1'b1, 3'b000, 32'd9, 32'h0000_00AA, 32'd0, 1'b0, "sb9");
        chk("sb9_mem2", mw(2), 32'h0000_AA00);
        do_req(1'b1, 3'b001, 32'd10, 32'h0000_1234, 32'd0, 1'b0, "sh10");
        chk("sh10_mem2", mw(2), 32'h1234_AA00);
        do_req(1'b0, 3'b010, 32'd8, 32'd0, 32'h1234_AA00, 1'b0, "lw8");
        do_req(1'b0, 3'b010, 32'd60, 32'd0, 32'h1111_000F, 1'b0, "lw_last");

        do_req(1'b1, 3'b010, 32'd6, 32'hFFFF_FFFF, 32'd0, 1'b1, "sw6_err");
        chk("sw6_mem1", mw(1), 32'h8081_7F01);
        do_req(1'b0, 3'b001, 32'd3, 32'd0, 32'd0, 1'b1, "lh3_err");
        do_req(1'b0, 3'b010, DEPTH*4, 32'd0, 32'd0, 1'b1, "lw_oob_err");
        do_req(1'b0, 3'b010, 32'h4000_0004, 32'd0, 32'd0, 1'b1, "lw_nowrap_err");
        do_req(1'b0, 3'b011, 32'd0, 32'd0, 32'd0, 1'b1, "ld011_err");
        do_req(1'b1, 3'b100, 32'd0, 32'h5555_5555, 32'd0, 1'b1, "st100_err");
        chk("st100_mem0", mw(0), 32'h1111_0000);

        // Back-pressure, plus a store offered during WAIT that must be ignored.
        resp_ready  = 1'b0;
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_funct3  = 3'b010;
        req_address = 32'd4;
        @(posedge clk); #1;
        req_write   = 1'b1;
        req_address = 32'd0;
        req_wdata   = 32'hBAD0_BAD0;
        chk("wait_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("stall_valid0", {31'd0, resp_valid}, 32'd1);
        chk("stall_rdata0", resp_rdata, 32'h8081_7F01);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_rdata", resp_rdata, 32'h8081_7F01);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", {31'd0, req_ready}, 32'd1);
        chk("wait_store_ignored", mw(0), 32'h1111_0000);

        // Reset during WAIT of an accepted store.
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_funct3  = 3'b010;
        req_address = 32'd0;
        req_wdata   = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sw0_visible", mw(0), 32'h1234_5678);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_no_valid", {31'd0, resp_valid}, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) chk("rst_mem", mw(i), iw(i));
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_memory.md
# load_store_memory

Parametrised data memory with a request/response handshake, replacing the single-cycle word-only data memory. It supports RV32I byte, halfword and word loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) using little-endian lane selection and load sign/zero extension. Latency is configurable and misaligned or out-of-range accesses are flagged. It sits between the CPU's ALU address path and the register write-back mux, and is preloaded from an initial-value array on reset.

## Interface
- DEPTH, 32, number of 32-bit words; ≥2.
- LATENCY, 1, cycles from request acceptance to `resp_valid`; ≥1.
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I load/store funct3.
- req_address  input  32  byte address.
- req_wdata  input  32  store data; low bits used for SB/SH.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  access was misaligned, out of range or illegal.
- initial_values  input  32×DEPTH  loaded into memory on reset.
- memory_check  output  32×DEPTH  live memory contents, for debug.

## Operation
- FSM states IDLE, WAIT, RESP.
  - `req_ready` = (state == IDLE).
  - IDLE → RESP on accept when LATENCY=1.
  - IDLE → WAIT on accept when LATENCY>1; the counter loads LATENCY−1.
  - WAIT decrements each cycle and goes to RESP when the counter reaches 1.
  - RESP → IDLE when `resp_ready`.
- Accept = `req_valid && req_ready`. At accept the block:
  - computes the word index = `req_address[31:2]`;
  - commits any store;
  - reads the addressed word;
  - latches the extended result and the error flag into response registers.
- Store merge:
  - SB (000) writes `wdata[7:0]` to lane `addr[1:0]`.
  - SH (001) writes `wdata[15:0]` to lanes {addr[1],0}/{addr[1],1}.
  - SW (010) writes the full word.
  - Unselected lanes are unchanged.
- Load extend:
  - LB (000) and LH (001) sign-extend the selected lane(s).
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) returns the word unchanged.
- Error conditions (any one sets `resp_error`; memory is not written and `resp_rdata` = 0):
  - halfword access with `addr[0]` = 1;
  - word access with `addr[1:0]` ≠ 0;
  - word index ≥ DEPTH; upper address bits are not wrapped;
  - load funct3 ∈ {011, 110, 111};
  - store funct3 ∉ {000, 001, 010}.
- Store response: `resp_rdata` = 0, with `resp_error` per the rules above.
- `resp_rdata` and `resp_error` are valid only while `resp_valid`. They hold stable in RESP until `resp_ready`.
- `memory_check` reflects `mem` combinationally.

## Timing
- Reset (posedge with reset = 1):
  - `mem[i]` ← `initial_values[i]`;
  - state ← IDLE, counter ← 0;
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_error` = 0;
  - `req_ready` = 1 from the following cycle.
- Reset wins over everything:
  - a request presented while reset is high is not accepted and not written;
  - reset mid-WAIT or mid-RESP drops the pending response with no `resp_valid` pulse.
- Accept at edge T → `resp_valid` = 1 during the cycle after edge T+LATENCY−1, i.e. visible LATENCY cycles after accept.
- A store is visible in `memory_check` the cycle after edge T.
- At most one request is outstanding. `req_ready` = 0 from accept until the edge where `resp_valid && resp_ready`.
- Minimum request spacing is LATENCY+1 cycles with `resp_ready` tied high.
- `resp_ready` held low keeps RESP indefinitely with outputs stable.
- `req_valid` asserted while `req_ready` = 0 is ignored. The requester must hold the request until accepted.

## Structure
- Package `lsu_pkg` contains:
  - `mem_funct3_t` enum (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101);
  - `lsu_state_t` enum {IDLE, WAIT, RESP}.
- Sub-module `load_align`: combinational word + `addr[1:0]` + funct3 → extended 32-bit load data.
- The top level holds the FSM, latency counter, store merge, error logic and memory array.
- Counter width is $clog2(LATENCY+1).

## Test plan
- Reset with `initial_values[1]` = 32'h8081_7F01, then LW addr 4 → `resp_rdata` 32'h8081_7F01, `resp_error` 0, `resp_valid` exactly LATENCY cycles after accept.
- Same preload, loads at addr 4/5/6/7:
  - LB addr 7 → 32'hFFFF_FF80;
  - LBU addr 7 → 32'h0000_0080;
  - LH addr 6 → 32'hFFFF_8081;
  - LHU addr 6 → 32'h0000_8081;
  - LB addr 5 → 32'h0000_007F.
- Preload word 2 = 0, then:
  - SB addr 9 wdata 32'hAA → `memory_check[2]` 32'h0000_AA00;
  - SH addr 10 wdata 32'h1234 → 32'h1234_AA00;
  - LW addr 8 → 32'h1234_AA00.
- Error cases, each with `resp_error` 1, `resp_rdata` 0 and memory unchanged:
  - SW addr 6;
  - LH addr 3;
  - LW addr DEPTH*4;
  - load funct3 011.
- LATENCY=3 with `resp_ready` low for 5 cycles → `req_ready` 0 throughout, response stable. Raise `resp_ready` → `req_ready` 1 the next cycle. A new request offered during WAIT is not accepted.
- Reset asserted during WAIT of an accepted SW → no `resp_valid` pulse. Memory equals `initial_values` after reset. `req_ready` 1 the next cycle.
